// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared constants for the pipeline hazard scoreboard.
//   REG_ADDR_W_DEFAULT : default register index width (32 architectural regs)
//   CAUSE_*            : bit positions inside the one-hot stall_cause vector
//   CAUSE_W            : width of stall_cause
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    localparam int CAUSE_LOAD_USE = 0;
    localparam int CAUSE_SB       = 1;
    localparam int CAUSE_FULL     = 2;
    localparam int CAUSE_DMEM     = 3;
    localparam int CAUSE_IMEM     = 4;
    localparam int CAUSE_W        = 5;

endpackage : hazard_pkg

// File: rtl/hazard_tag_fifo.sv
// ---------------------------------------------------------------------------
// hazard_tag_fifo
// In-order FIFO of destination-register tags for outstanding loads.
// Circular read/write pointers wrap at DEPTH; an occupancy count gives
// full/empty. Illegal operations are dropped and flagged with a 1-cycle
// error pulse.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   push, push_data      : enqueue a tag
//   pop                  : dequeue the head tag
//   head                 : current head tag (0 while empty)
//   full, empty          : occupancy status
//   push_err             : push while full without a simultaneous pop
//   pop_err              : pop while empty
// ---------------------------------------------------------------------------
module hazard_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             push_err,
    output logic             pop_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot the push needs, so push+pop is legal when full.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign push_err = push && !do_push;
    assign pop_err  = pop && empty;

    // Stale storage is hidden while empty so the head reads 0 after reset.
    assign head = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the tag storage is deliberately not reset; valid-entry tracking
    // lives in the pointers/count, and the head output masks stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule : hazard_tag_fifo

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Pipeline hazard unit with non-blocking load support. Combines the EX-stage
// load-use check with a register scoreboard and in-order load tag FIFO,
// resolves stall/flush priority (a taken branch kills the ID instruction),
// reports stall causes, keeps saturating performance counters and watches
// for missing load responses.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   rs1_id, rs2_id, rs1_used,
//   rs2_used, id_is_load, rd_id     : ID-stage instruction operands
//   memread_id_ex, rd_id_ex         : EX-stage load and its destination
//   load_issue, load_issue_rd       : load accepted by data memory
//   load_resp                       : in-order load data return
//   branch_taken                    : taken branch/jump resolved in EX
//   imem_ready, dmem_valid,
//   dmem_ready                      : memory handshakes
//   stall                           : hold PC and IF/ID
//   flush_if_id, flush_id_ex        : pipeline register flushes
//   load_resp_rd                    : writeback destination of load_resp
//   lq_full, lq_empty               : tag FIFO status
//   stall_cause                     : one-hot {imem, dmem, full, sb, load_use}
//   stall_cycles, flush_count       : saturating performance counters
//   proto_err, timeout_err          : sticky error flags
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = REG_ADDR_W_DEFAULT,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 32,
    parameter int TIMEOUT_CYC     = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  memread_id_ex,
    input  logic [REG_ADDR_W-1:0] rd_id_ex,
    input  logic                  load_issue,
    input  logic [REG_ADDR_W-1:0] load_issue_rd,
    input  logic                  load_resp,
    input  logic                  branch_taken,
    input  logic                  imem_ready,
    input  logic                  dmem_valid,
    input  logic                  dmem_ready,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [REG_ADDR_W-1:0] load_resp_rd,
    output logic                  lq_full,
    output logic                  lq_empty,
    output logic [CAUSE_W-1:0]    stall_cause,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  proto_err,
    output logic                  timeout_err
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int WD_W     = $clog2(TIMEOUT_CYC + 1);

    logic [NUM_REGS-1:0] sb;
    logic [WD_W-1:0]     wd_cnt;
    logic                push_err;
    logic                pop_err;
    logic                push_ok;
    logic                pop_ok;

    logic                load_use_haz;
    logic                rs1_sb_haz;
    logic                rs2_sb_haz;
    logic                sb_haz;
    logic                full_haz;
    logic                waw_haz;
    logic                imem_stall;
    logic                dmem_stall;
    logic [CAUSE_W-1:0]  cause;

    // ---------------- load tag FIFO ----------------
    hazard_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (REG_ADDR_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (load_issue),
        .push_data (load_issue_rd),
        .pop       (load_resp),
        .head      (load_resp_rd),
        .full      (lq_full),
        .empty     (lq_empty),
        .push_err  (push_err),
        .pop_err   (pop_err)
    );

    assign push_ok = load_issue && !push_err;
    assign pop_ok  = load_resp && !pop_err;

    // ---------------- hazard terms ----------------
    assign load_use_haz = memread_id_ex && (rd_id_ex != '0) &&
                          ((rs1_used && (rs1_id == rd_id_ex)) ||
                           (rs2_used && (rs2_id == rd_id_ex)));

    // A register whose load returns this cycle is forwarded, not stalled on.
    assign rs1_sb_haz = rs1_used && (rs1_id != '0) && sb[rs1_id] &&
                        !(load_resp && (load_resp_rd == rs1_id));
    assign rs2_sb_haz = rs2_used && (rs2_id != '0) && sb[rs2_id] &&
                        !(load_resp && (load_resp_rd == rs2_id));
    assign sb_haz     = rs1_sb_haz || rs2_sb_haz;

    assign full_haz   = id_is_load && lq_full && !load_resp;
    assign waw_haz    = id_is_load && (rd_id != '0) && sb[rd_id];
    assign imem_stall = !imem_ready;
    assign dmem_stall = dmem_valid && !dmem_ready;

    // Memory stalls always apply; ID-instruction hazards are dropped when a
    // taken branch is about to kill that instruction.
    // NOTE: every bit gets a default before conditional updates so the
    // block stays purely combinational.
    always_comb begin
        cause = '0;
        cause[CAUSE_IMEM] = imem_stall;
        cause[CAUSE_DMEM] = dmem_stall;
        if (!branch_taken) begin
            cause[CAUSE_LOAD_USE] = load_use_haz;
            cause[CAUSE_SB]       = sb_haz || waw_haz;
            cause[CAUSE_FULL]     = full_haz;
        end
    end

    assign stall_cause = cause;
    assign stall       = |cause;
    assign flush_if_id = branch_taken;

    // Scoreboard/FIFO bubbles are held back while a memory stall freezes the
    // whole pipe; the bubble would otherwise overwrite a frozen EX entry.
    assign flush_id_ex = branch_taken || cause[CAUSE_LOAD_USE] ||
                         ((cause[CAUSE_SB] || cause[CAUSE_FULL]) &&
                          !imem_stall && !dmem_stall);

    // ---------------- scoreboard ----------------
    // The set is written after the clear so a same-cycle set of the same
    // register wins. Register 0 is never marked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            if (pop_ok) sb[load_resp_rd] <= 1'b0;
            if (push_ok && (load_issue_rd != '0)) sb[load_issue_rd] <= 1'b1;
        end
    end

    // ---------------- performance counters ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_taken && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    // ---------------- error flags and watchdog ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            if (push_err || pop_err) proto_err <= 1'b1;

            if (lq_empty || load_resp) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(TIMEOUT_CYC)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) timeout_err <= 1'b1;
            end
        end
    end

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed scenarios followed by randomized traffic. Expected values come
// from a queue-based reference: outstanding loads are an ordered list of
// tags and a register is "pending" when its tag is in that list.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int RW   = 5;
    localparam int MAXO = 2;
    localparam int CW   = 32;
    localparam int TO   = 256;

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] rs1_id, rs2_id, rd_id, rd_id_ex, load_issue_rd;
    logic          rs1_used, rs2_used, id_is_load, memread_id_ex;
    logic          load_issue, load_resp, branch_taken;
    logic          imem_ready, dmem_valid, dmem_ready;
    logic          stall, flush_if_id, flush_id_ex, lq_full, lq_empty;
    logic [RW-1:0] load_resp_rd;
    logic [4:0]    stall_cause;
    logic [CW-1:0] stall_cycles, flush_count;
    logic          proto_err, timeout_err;

    hazard_scoreboard #(
        .REG_ADDR_W      (RW),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CW),
        .TIMEOUT_CYC     (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .id_is_load    (id_is_load),
        .rd_id         (rd_id),
        .memread_id_ex (memread_id_ex),
        .rd_id_ex      (rd_id_ex),
        .load_issue    (load_issue),
        .load_issue_rd (load_issue_rd),
        .load_resp     (load_resp),
        .branch_taken  (branch_taken),
        .imem_ready    (imem_ready),
        .dmem_valid    (dmem_valid),
        .dmem_ready    (dmem_ready),
        .stall         (stall),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .load_resp_rd  (load_resp_rd),
        .lq_full       (lq_full),
        .lq_empty      (lq_empty),
        .stall_cause   (stall_cause),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .proto_err     (proto_err),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    int          q[$];
    int unsigned m_stall;
    int unsigned m_flush;
    bit          m_proto;
    bit          m_timeout;
    int          m_wd;

    function automatic bit pending(input int r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit blocked(input bit used, input int r);
        return used && pending(r) && !(load_resp && (q.size() > 0) && (q[0] == r));
    endfunction

    function automatic logic [4:0] exp_cause();
        logic [4:0] c;
        bit lu, sbh, fl, ww;
        lu  = memread_id_ex && (rd_id_ex != 0) &&
              ((rs1_used && rs1_id == rd_id_ex) || (rs2_used && rs2_id == rd_id_ex));
        sbh = blocked(rs1_used, int'(rs1_id)) || blocked(rs2_used, int'(rs2_id));
        fl  = id_is_load && (q.size() == MAXO) && !load_resp;
        ww  = id_is_load && pending(int'(rd_id));
        c = 5'b0;
        c[4] = !imem_ready;
        c[3] = dmem_valid && !dmem_ready;
        if (!branch_taken) begin
            c[2] = fl;
            c[1] = sbh || ww;
            c[0] = lu;
        end
        return c;
    endfunction

    task automatic model_check(input string ph);
        logic [4:0] c;
        bit         mem_frz;
        c       = exp_cause();
        mem_frz = !imem_ready || (dmem_valid && !dmem_ready);
        check({ph, ".stall"}, stall, c != 5'b0);
        check({ph, ".cause"}, stall_cause, c);
        check({ph, ".flush_if_id"}, flush_if_id, branch_taken);
        check({ph, ".flush_id_ex"}, flush_id_ex,
              branch_taken || c[0] || ((c[1] || c[2]) && !mem_frz));
        check({ph, ".load_resp_rd"}, load_resp_rd, (q.size() > 0) ? q[0] : 0);
        check({ph, ".lq_full"}, lq_full, q.size() == MAXO);
        check({ph, ".lq_empty"}, lq_empty, q.size() == 0);
        check({ph, ".stall_cycles"}, stall_cycles, m_stall);
        check({ph, ".flush_count"}, flush_count, m_flush);
        check({ph, ".proto_err"}, proto_err, m_proto);
        check({ph, ".timeout_err"}, timeout_err, m_timeout);
    endtask

    // Advance one clock edge and update the model with the inputs that edge saw.
    task automatic tick();
        bit st, pop_ok, push_ok;
        int sz;
        st = (exp_cause() != 5'b0);
        sz = q.size();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_stall = 0; m_flush = 0; m_proto = 0; m_timeout = 0; m_wd = 0;
        end else begin
            pop_ok  = load_resp && (sz > 0);
            push_ok = load_issue && ((sz < MAXO) || pop_ok);
            if (load_resp && sz == 0) m_proto = 1'b1;
            if (load_issue && !push_ok) m_proto = 1'b1;
            if (st && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (branch_taken && m_flush != 32'hFFFF_FFFF) m_flush++;
            if (sz == 0 || load_resp) m_wd = 0;
            else if (m_wd < TO) m_wd++;
            if (m_wd >= TO) m_timeout = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back(int'(load_issue_rd));
        end
        @(negedge clk);
    endtask

    task automatic step(input string ph);
        #1;
        model_check(ph);
        tick();
    endtask

    task automatic idle();
        rs1_id = '0; rs2_id = '0; rd_id = '0; rd_id_ex = '0; load_issue_rd = '0;
        rs1_used = 0; rs2_used = 0; id_is_load = 0; memread_id_ex = 0;
        load_issue = 0; load_resp = 0; branch_taken = 0;
        imem_ready = 1; dmem_valid = 0; dmem_ready = 1;
    endtask

    initial begin
        int r;
        bit want;

        // ---------------- reset ----------------
        idle();
        rst_n = 0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1;
        #1;
        check("rst.stall", stall, 0);
        check("rst.lq_empty", lq_empty, 1);
        check("rst.lq_full", lq_full, 0);
        check("rst.load_resp_rd", load_resp_rd, 0);
        check("rst.stall_cycles", stall_cycles, 0);
        check("rst.flush_count", flush_count, 0);
        check("rst.proto_err", proto_err, 0);
        check("rst.timeout_err", timeout_err, 0);

        // ---------------- EX load-use, then killed by a branch ----------------
        memread_id_ex = 1; rd_id_ex = 5; rs1_id = 5; rs1_used = 1;
        #1;
        check("lu.stall", stall, 1);
        check("lu.flush_id_ex", flush_id_ex, 1);
        check("lu.flush_if_id", flush_if_id, 0);
        check("lu.cause", stall_cause, 5'b00001);
        step("lu");
        branch_taken = 1;
        #1;
        check("lu_br.stall", stall, 0);
        check("lu_br.flush_if_id", flush_if_id, 1);
        check("lu_br.flush_id_ex", flush_id_ex, 1);
        check("lu_br.cause", stall_cause, 5'b00000);
        step("lu_br");
        branch_taken = 0; memread_id_ex = 0; rs1_used = 0;
        #1;
        check("lu_br.flush_count", flush_count, 1);
        check("lu_br.stall_cycles", stall_cycles, 1);

        // ---------------- fill FIFO, full and sb hazards, in-order pops -------
        load_issue = 1; load_issue_rd = 3;
        step("iss3");
        load_issue_rd = 7;
        step("iss7");
        load_issue = 0;
        id_is_load = 1; rd_id = 1;
        #1;
        check("full.lq_full", lq_full, 1);
        check("full.stall", stall, 1);
        check("full.cause", stall_cause, 5'b00100);
        step("full");
        id_is_load = 0; rs2_id = 7; rs2_used = 1;
        #1;
        check("sb7.stall", stall, 1);
        check("sb7.cause", stall_cause, 5'b00010);
        step("sb7");
        load_resp = 1;
        #1;
        check("resp1.load_resp_rd", load_resp_rd, 3);
        check("resp1.stall", stall, 1);
        step("resp1");
        #1;
        check("resp2.load_resp_rd", load_resp_rd, 7);
        check("resp2.stall_fwd", stall, 0);
        step("resp2");
        load_resp = 0; rs2_used = 0;
        #1;
        check("drain.lq_empty", lq_empty, 1);

        // ---------------- push+pop when full, then overflow ----------------
        load_issue = 1; load_issue_rd = 3;
        step("pp_iss3");
        load_issue_rd = 7;
        step("pp_iss7");
        load_issue_rd = 9; load_resp = 1;
        step("pushpop");
        load_issue = 0; load_resp = 0; rs1_id = 9; rs1_used = 1;
        #1;
        check("pushpop.lq_full", lq_full, 1);
        check("pushpop.head", load_resp_rd, 7);
        check("pushpop.proto_err", proto_err, 0);
        check("pushpop.sb9_cause", stall_cause, 5'b00010);
        step("pp_sb9");
        rs1_used = 0; load_issue = 1; load_issue_rd = 11;
        step("overflow");
        load_issue = 0; rs1_id = 11; rs1_used = 1;
        #1;
        check("overflow.proto_err", proto_err, 1);
        check("overflow.lq_full", lq_full, 1);
        check("overflow.head", load_resp_rd, 7);
        check("overflow.no_sb11", stall, 0);
        step("ovf_chk");
        rs1_used = 0; load_resp = 1;
        step("ovf_pop7");
        step("ovf_pop9");
        load_resp = 0;
        #1;
        check("ovf.lq_empty", lq_empty, 1);

        // ---------------- load to x0 ----------------
        load_issue = 1; load_issue_rd = 0;
        step("x0_iss");
        load_issue = 0; rs1_id = 0; rs1_used = 1; id_is_load = 1; rd_id = 0;
        #1;
        check("x0.lq_empty", lq_empty, 0);
        check("x0.lq_full", lq_full, 0);
        check("x0.head", load_resp_rd, 0);
        check("x0.stall", stall, 0);
        step("x0");
        rs1_used = 0; id_is_load = 0; load_resp = 1;
        step("x0_pop");
        load_resp = 0;

        // ---------------- watchdog ----------------
        load_issue = 1; load_issue_rd = 6;
        step("wd_iss");
        load_issue = 0;
        for (int i = 0; i < TO - 1; i++) step("wd");
        #1;
        check("wd.before", timeout_err, 0);
        step("wd_last");
        #1;
        check("wd.at_limit", timeout_err, 1);
        for (int i = 0; i < 5; i++) step("wd_hold");
        #1;
        check("wd.sticky", timeout_err, 1);

        // ---------------- reset mid-operation ----------------
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        check("rst2.lq_empty", lq_empty, 1);
        check("rst2.lq_full", lq_full, 0);
        check("rst2.head", load_resp_rd, 0);
        check("rst2.timeout_err", timeout_err, 0);
        check("rst2.proto_err", proto_err, 0);
        check("rst2.stall_cycles", stall_cycles, 0);
        check("rst2.flush_count", flush_count, 0);
        check("rst2.stall", stall, 0);
        load_resp = 1;
        step("late_resp");
        load_resp = 0;
        #1;
        check("late_resp.proto_err", proto_err, 1);
        rst_n = 0;
        tick();
        rst_n = 1;

        // ---------------- imem stall during an sb hazard ----------------
        load_issue = 1; load_issue_rd = 4;
        step("im_iss");
        load_issue = 0; rs1_id = 4; rs1_used = 1; imem_ready = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("imem.cause", stall_cause, 5'b10010);
            check("imem.flush_id_ex", flush_id_ex, 0);
            step("imem");
        end
        imem_ready = 1;
        #1;
        check("imem.stall_cycles", stall_cycles, 10);
        rs1_used = 0; load_resp = 1;
        step("im_pop");
        idle();

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 600; n++) begin
            rs1_id        = RW'($urandom_range(0, 7));
            rs2_id        = RW'($urandom_range(0, 7));
            rs1_used      = $urandom_range(0, 1) == 1;
            rs2_used      = $urandom_range(0, 1) == 1;
            id_is_load    = $urandom_range(0, 2) == 0;
            rd_id         = RW'($urandom_range(0, 7));
            memread_id_ex = $urandom_range(0, 2) == 0;
            rd_id_ex      = RW'($urandom_range(0, 7));
            branch_taken  = $urandom_range(0, 7) == 0;
            imem_ready    = $urandom_range(0, 7) != 0;
            dmem_valid    = $urandom_range(0, 1) == 1;
            dmem_ready    = $urandom_range(0, 3) != 0;
            load_resp     = ($urandom_range(0, 2) == 0) &&
                            ((q.size() > 0) || ($urandom_range(0, 31) == 0));
            want          = $urandom_range(0, 1) == 1;
            load_issue    = want && ((q.size() < MAXO) || load_resp ||
                                     ($urandom_range(0, 31) == 0));
            r = int'($urandom_range(0, 7));
            if (pending(r)) r = 0;
            load_issue_rd = RW'(r);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_scoreboard
